// File: rtl/pic_ctrl_n.sv
// pic_ctrl_n: parametrised programmable interrupt controller.
// Optional special mask mode under `PIC_SPECIAL_MASK_EN.
module pic_ctrl_n #(
   parameter int          NUM_IRQ = 16,
   parameter logic [7:0]  VEC_RST = 8'h20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               reg_we,
   input  logic               reg_re,
   input  logic [2:0]         reg_addr,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata,
   output logic               int_out,
   input  logic               int_ack,
   output logic [7:0]         vec_out,
   output logic               vec_valid
);

   localparam logic [7:0] SPUR = 8'(NUM_IRQ - 1);

   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] irr_q, irr_d;
   logic [NUM_IRQ-1:0] isr_q, isr_d;
   logic [NUM_IRQ-1:0] imr_q, imr_d;
   logic [NUM_IRQ-1:0] trig_q, trig_d;
   logic [4:0]         ptr_q, ptr_d;
   logic               rotate_q, rotate_d;
   logic               aeoi_q, aeoi_d;
   logic               smm_q, smm_d;
   logic [7:0]         vbase_q, vbase_d;
   logic               int_out_q, int_out_d;
   logic [7:0]         vec_out_q, vec_out_d;
   logic               vec_valid_q, vec_valid_d;
   logic [31:0]        rdata_q, rdata_d;

   logic               win_hit, blk_hit, top_hit;
   logic [4:0]         win_idx, blk_idx, top_idx;
   logic [5:0]         win_rel, blk_rel, top_rel;
   logic               ack_ok;
   logic               eoi_hit;
   logic [4:0]         eoi_k;
   logic [NUM_IRQ-1:0] isr_eff;

   // Highest-priority set bit of v relative to rotation pointer p.
   function automatic void pick(
      input  logic [NUM_IRQ-1:0] v,
      input  logic [4:0]         p,
      output logic               hit,
      output logic [4:0]         idx,
      output logic [5:0]         rel
   );
      int r;
      hit = 1'b0;
      idx = '0;
      rel = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         r = (i - int'(p) + NUM_IRQ) % NUM_IRQ;
         if (v[i] && (!hit || 6'(r) < rel)) begin
            hit = 1'b1;
            idx = 5'(i);
            rel = 6'(r);
         end
      end
   endfunction

   function automatic logic [4:0] nxt(input logic [4:0] k);
      return 5'((int'(k) + 1) % NUM_IRQ);
   endfunction

   function automatic logic [31:0] ext(input logic [NUM_IRQ-1:0] v);
      logic [31:0] r;
      r = '0;
      r[NUM_IRQ-1:0] = v;
      return r;
   endfunction

   // Priority resolution: pending winner, blocking ISR level, EOI target.
   always_comb begin
      isr_eff = isr_q & ~(imr_q & {NUM_IRQ{smm_q}});
      pick(irr_q & ~imr_q, ptr_q, win_hit, win_idx, win_rel);
      pick(isr_eff, ptr_q, blk_hit, blk_idx, blk_rel);
      pick(isr_q, ptr_q, top_hit, top_idx, top_rel);
   end

   // Next-state logic for registers, IRR/ISR, rotation and CPU handshake.
   always_comb begin
      irr_d       = irr_q;
      isr_d       = isr_q;
      imr_d       = imr_q;
      trig_d      = trig_q;
      ptr_d       = ptr_q;
      rotate_d    = rotate_q;
      aeoi_d      = aeoi_q;
      smm_d       = smm_q;
      vbase_d     = vbase_q;
      vec_out_d   = vec_out_q;
      rdata_d     = rdata_q;
      eoi_hit     = 1'b0;
      eoi_k       = '0;
      ack_ok      = int_ack && int_out_q && win_hit;
      vec_valid_d = int_ack;

      if (reg_we) begin
         unique case (reg_addr)
            3'd0: begin
               rotate_d = reg_wdata[0];
               aeoi_d   = reg_wdata[1];
`ifdef PIC_SPECIAL_MASK_EN
               smm_d    = reg_wdata[2];
`endif
               vbase_d  = reg_wdata[15:8];
            end
            3'd1: imr_d  = reg_wdata[NUM_IRQ-1:0];
            3'd2: trig_d = reg_wdata[NUM_IRQ-1:0];
            3'd5: begin
               if (reg_wdata[31]) begin
                  for (int i = 0; i < NUM_IRQ; i++)
                     if (reg_wdata[4:0] == 5'(i) && isr_q[i]) begin
                        eoi_hit = 1'b1;
                        eoi_k   = 5'(i);
                     end
               end else if (top_hit) begin
                  eoi_hit = 1'b1;
                  eoi_k   = top_idx;
               end
            end
            default: ;
         endcase
      end

      // EOI lands first so a same-cycle ack can set its own bit.
      if (eoi_hit) begin
         for (int i = 0; i < NUM_IRQ; i++)
            if (eoi_k == 5'(i)) isr_d[i] = 1'b0;
         if (rotate_q) ptr_d = nxt(eoi_k);
      end

      if (ack_ok) begin
         if (!aeoi_q) begin
            for (int i = 0; i < NUM_IRQ; i++)
               if (win_idx == 5'(i)) isr_d[i] = 1'b1;
         end else if (rotate_q) begin
            ptr_d = nxt(win_idx);
         end
      end

      if (!rotate_q) ptr_d = '0;

      // A fresh edge wins over the ack clear of the same line.
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (trig_q[i]) begin
            if (ack_ok && win_idx == 5'(i)) irr_d[i] = 1'b0;
            if (irq_in[i] && !irq_q[i]) irr_d[i] = 1'b1;
         end else begin
            irr_d[i] = irq_in[i];
         end
      end

      if (int_ack)
         vec_out_d = ack_ok ? vbase_q + {3'b000, win_idx} : vbase_q + SPUR;

      int_out_d = !int_ack && win_hit && (!blk_hit || blk_rel > win_rel);

      if (reg_re) begin
         unique case (reg_addr)
            3'd0:    rdata_d = {16'h0, vbase_q, 5'h0, smm_q, aeoi_q, rotate_q};
            3'd1:    rdata_d = ext(imr_q);
            3'd2:    rdata_d = ext(trig_q);
            3'd3:    rdata_d = ext(irr_q);
            3'd4:    rdata_d = ext(isr_q);
            default: rdata_d = '0;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q       <= '0;
         irr_q       <= '0;
         isr_q       <= '0;
         imr_q       <= '1;
         trig_q      <= '0;
         ptr_q       <= '0;
         rotate_q    <= 1'b0;
         aeoi_q      <= 1'b0;
         smm_q       <= 1'b0;
         vbase_q     <= VEC_RST;
         int_out_q   <= 1'b0;
         vec_out_q   <= '0;
         vec_valid_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         irq_q       <= irq_in;
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         imr_q       <= imr_d;
         trig_q      <= trig_d;
         ptr_q       <= ptr_d;
         rotate_q    <= rotate_d;
         aeoi_q      <= aeoi_d;
         smm_q       <= smm_d;
         vbase_q     <= vbase_d;
         int_out_q   <= int_out_d;
         vec_out_q   <= vec_out_d;
         vec_valid_q <= vec_valid_d;
         rdata_q     <= rdata_d;
      end
   end

   assign reg_rdata = rdata_q;
   assign int_out   = int_out_q;
   assign vec_out   = vec_out_q;
   assign vec_valid = vec_valid_q;

   logic unused_ok;
   assign unused_ok = ^{reg_wdata, blk_idx, top_rel};

endmodule

// File: tb/tb_pic_ctrl_n.sv
// tb_pic_ctrl_n: directed bench for pic_ctrl_n (NUM_IRQ=16).
// Build with +define+PIC_SPECIAL_MASK_EN to cover special mask mode.
module tb_pic_ctrl_n;

   logic        clk;
   logic        rst;
   logic [15:0] irq_in;
   logic        reg_we;
   logic        reg_re;
   logic [2:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        int_out;
   logic        int_ack;
   logic [7:0]  vec_out;
   logic        vec_valid;

   int checks = 0;
   int errors = 0;

   pic_ctrl_n #(.NUM_IRQ(16), .VEC_RST(8'h20)) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_in    (irq_in),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .int_out   (int_out),
      .int_ack   (int_ack),
      .vec_out   (vec_out),
      .vec_valid (vec_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      reg_we    = 1'b1;
      reg_addr  = a;
      reg_wdata = d;
      tick();
      reg_we    = 1'b0;
      reg_wdata = '0;
   endtask

   task automatic rd(input logic [2:0] a, input string tag,
                     input logic [31:0] exp);
      reg_re   = 1'b1;
      reg_addr = a;
      tick();
      reg_re   = 1'b0;
      chk(tag, reg_rdata, exp);
   endtask

   // Ack pulse; checks vector and vec_valid together as {valid, vec}.
   task automatic ack(input string tag, input logic [7:0] v);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      chk(tag, {23'h0, vec_valid, vec_out}, {23'h0, 1'b1, v});
   endtask

   initial begin
      rst       = 1'b1;
      irq_in    = '0;
      reg_we    = 1'b0;
      reg_re    = 1'b0;
      reg_addr  = '0;
      reg_wdata = '0;
      int_ack   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_int_out", 32'(int_out), 32'h0);
      chk("rst_vec", {23'h0, vec_valid, vec_out}, 32'h0);
      chk("rst_rdata", reg_rdata, 32'h0);
      rd(3'd1, "rst_imr", 32'h0000_FFFF);
      rd(3'd0, "rst_ctrl", 32'h0000_2000);
      rd(3'd2, "rst_trig", 32'h0);
      rd(3'd6, "rd_addr6", 32'h0);

      // edge line 2, two-cycle latency, ack
      wr(3'd1, 32'h0);
      wr(3'd2, 32'h0000_0004);
      irq_in = 16'h0004;
      tick();
      chk("t2_lat1", 32'(int_out), 32'h0);
      tick();
      chk("t2_lat2", 32'(int_out), 32'h1);
      ack("t2_vec", 8'h22);
      chk("t2_drop", 32'(int_out), 32'h0);
      tick();
      chk("t2_vv_pulse", 32'(vec_valid), 32'h0);
      rd(3'd4, "t2_isr", 32'h0000_0004);
      rd(3'd3, "t2_irr", 32'h0);
      wr(3'd5, 32'h8000_0002);
      rd(3'd4, "t2_isr_clr", 32'h0);
      irq_in = '0;

      // nesting block and non-specific EOI
      wr(3'd2, 32'h0000_0224);
      irq_in = 16'h0020;
      tick();
      tick();
      chk("t3_int5", 32'(int_out), 32'h1);
      ack("t3_vec5", 8'h25);
      irq_in = 16'h0220;
      repeat (3) tick();
      chk("t3_blocked", 32'(int_out), 32'h0);
      rd(3'd3, "t3_irr", 32'h0000_0200);
      rd(3'd4, "t3_isr", 32'h0000_0020);
      wr(3'd5, 32'h0);
      chk("t3_eoi_1st", 32'(int_out), 32'h0);
      tick();
      chk("t3_eoi_2nd", 32'(int_out), 32'h1);
      ack("t3_vec9", 8'h29);
      wr(3'd5, 32'h0);
      rd(3'd4, "t3_isr_clr", 32'h0);
      irq_in = '0;

      // rotating priority
      wr(3'd0, 32'h0000_2001);
      wr(3'd2, 32'h0000_0009);
      irq_in = 16'h0009;
      tick();
      tick();
      chk("t4_int", 32'(int_out), 32'h1);
      ack("t4_vec0", 8'h20);
      tick();
      chk("t4_blk0", 32'(int_out), 32'h0);
      irq_in = 16'h0008;
      tick();
      irq_in = 16'h0009;
      tick();
      wr(3'd5, 32'h0);
      tick();
      chk("t4_int3", 32'(int_out), 32'h1);
      ack("t4_vec3", 8'h23);
      wr(3'd5, 32'h0);
      tick();
      chk("t4_int0", 32'(int_out), 32'h1);
      ack("t4_vec0b", 8'h20);
      wr(3'd5, 32'h0);
      wr(3'd0, 32'h0000_2000);
      irq_in = '0;
      rd(3'd4, "t4_isr", 32'h0);

      // AEOI and spurious ack
      wr(3'd0, 32'h0000_2002);
      wr(3'd2, 32'h0000_0002);
      irq_in = 16'h0002;
      tick();
      tick();
      chk("t5_int1", 32'(int_out), 32'h1);
      ack("t5_vec1", 8'h21);
      rd(3'd4, "t5_isr_aeoi", 32'h0);
      chk("t5_idle", 32'(int_out), 32'h0);
      ack("t5_spur", 8'h2F);
      rd(3'd3, "t5_irr", 32'h0);

      // level line dropped before ack
      wr(3'd0, 32'h0000_2000);
      irq_in = 16'h0042;
      tick();
      tick();
      chk("lvl_int", 32'(int_out), 32'h1);
      irq_in = 16'h0002;
      tick();
      tick();
      chk("lvl_drop", 32'(int_out), 32'h0);
      ack("lvl_spur", 8'h2F);
      rd(3'd4, "lvl_isr", 32'h0);

      // special mask mode
      irq_in = '0;
      tick();
      irq_in = 16'h0002;
      tick();
      tick();
      chk("t6_int1", 32'(int_out), 32'h1);
      ack("t6_vec1", 8'h21);
      wr(3'd0, 32'h0000_2004);
`ifdef PIC_SPECIAL_MASK_EN
      rd(3'd0, "t6_ctrl", 32'h0000_2004);
`else
      rd(3'd0, "t6_ctrl", 32'h0000_2000);
`endif
      wr(3'd1, 32'h0000_0002);
      irq_in = 16'h0012;
      repeat (3) tick();
`ifdef PIC_SPECIAL_MASK_EN
      chk("t6_smm_int", 32'(int_out), 32'h1);
      ack("t6_vec4", 8'h24);
`else
      chk("t6_strict", 32'(int_out), 32'h0);
      rd(3'd4, "t6_isr", 32'h0000_0002);
`endif

      // reset during an ack
      int_ack = 1'b1;
      #2 rst = 1'b1;
      tick();
      chk("rst_mid_vv", {30'h0, vec_valid, int_out}, 32'h0);
      int_ack = 1'b0;
      rst     = 1'b0;
      irq_in  = '0;
      rd(3'd1, "rst2_imr", 32'h0000_FFFF);
      rd(3'd0, "rst2_ctrl", 32'h0000_2000);
      rd(3'd4, "rst2_isr", 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
